// File: rtl/param_rom_stream_ctrl_if.sv
// Parameter-ROM stream bundle: job control, ROM port and output stream.
// PARAM_STREAM_LAST_EN adds the data_out_last flag.
interface param_rom_stream_ctrl_if #(
   parameter int DATA_WIDTH = 16,
   parameter int OUT_DEPTH  = 32,
   parameter int PASS_WIDTH = 16
);
   logic                       start;
   logic [PASS_WIDTH-1:0]      pass_count;
   logic                       busy;
   logic                       done;
   logic [$clog2(OUT_DEPTH):0] rom_addr;
   logic                       rom_ce;
   logic [DATA_WIDTH-1:0]      rom_q;
   logic [DATA_WIDTH-1:0]      data_out;
   logic                       data_out_valid;
   logic                       data_out_ready;
`ifdef PARAM_STREAM_LAST_EN
   logic                       data_out_last;

   modport master (
      input  start, pass_count, rom_q, data_out_ready,
      output busy, done, rom_addr, rom_ce,
      output data_out, data_out_valid, data_out_last
   );
   modport slave (
      output start, pass_count, rom_q, data_out_ready,
      input  busy, done, rom_addr, rom_ce,
      input  data_out, data_out_valid, data_out_last
   );
`else
   modport master (
      input  start, pass_count, rom_q, data_out_ready,
      output busy, done, rom_addr, rom_ce,
      output data_out, data_out_valid
   );
   modport slave (
      output start, pass_count, rom_q, data_out_ready,
      input  busy, done, rom_addr, rom_ce,
      input  data_out, data_out_valid
   );
`endif
endinterface

// File: rtl/param_rom_stream_ctrl.sv
// Walks a fixed-latency parameter ROM for N passes into a credit-based stream.
// Optional macro PARAM_STREAM_LAST_EN: per-pass last flag on the stream.
module param_rom_stream_ctrl #(
   parameter int DATA_WIDTH  = 16,
   parameter int OUT_DEPTH   = 32,
   parameter int ROM_LATENCY = 2,
   parameter int FIFO_DEPTH  = ROM_LATENCY + 1,
   parameter int PASS_WIDTH  = 16
) (
   input logic clk,
   input logic rst,
   param_rom_stream_ctrl_if.master bus
);
   localparam int AW = $clog2(OUT_DEPTH) + 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(OUT_DEPTH - 1);
   localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                r_state;
   logic [AW-1:0]         r_addr;
   logic [PASS_WIDTH-1:0] r_passes;
   logic                  r_busy;
   logic                  r_done;
   logic [ROM_LATENCY-1:0] r_vsr;
   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]         r_rd_ptr;
   logic [PW-1:0]         r_wr_ptr;
   logic [CW-1:0]         r_count;
`ifdef PARAM_STREAM_LAST_EN
   logic [ROM_LATENCY-1:0] r_lsr;
   logic                  r_lmem [FIFO_DEPTH];
`endif

   int            w_inflight;
   logic          w_pop;
   logic          w_push;
   logic          w_issue;
   logic          w_wrap;
   logic          w_drained;
   logic [CW-1:0] w_count_nxt;

   always_comb begin
      w_inflight = 0;
      for (int i = 0; i < ROM_LATENCY; i++)
         w_inflight = w_inflight + int'(r_vsr[i]);
   end

   assign w_pop  = (r_count != '0) && bus.data_out_ready;
   assign w_push = r_vsr[ROM_LATENCY-1];
   // Credits: words in flight plus words buffered never exceed FIFO_DEPTH.
   assign w_issue = (r_state == S_RUN) &&
      ((w_inflight + int'(r_count) - int'(w_pop)) < FIFO_DEPTH);
   assign w_wrap = w_issue && (r_addr == LAST_ADDR);
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
   // Look one cycle ahead so done lands right after the final handshake.
   assign w_drained = (w_inflight == int'(r_vsr[ROM_LATENCY-1])) &&
      (w_count_nxt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_addr   <= '0;
         r_passes <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start && bus.pass_count != '0) begin
                  r_state  <= S_RUN;
                  r_passes <= bus.pass_count;
                  r_addr   <= '0;
                  r_busy   <= 1'b1;
               end
            end
            S_RUN: begin
               if (w_issue) begin
                  r_addr <= w_wrap ? '0 : r_addr + AW'(1);
                  if (w_wrap) begin
                     r_passes <= r_passes - PASS_WIDTH'(1);
                     if (r_passes == PASS_WIDTH'(1))
                        r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (w_drained) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vsr    <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
`ifdef PARAM_STREAM_LAST_EN
         r_lsr    <= '0;
`endif
      end else begin
         r_vsr[0] <= w_issue;
         for (int i = 1; i < ROM_LATENCY; i++)
            r_vsr[i] <= r_vsr[i-1];
`ifdef PARAM_STREAM_LAST_EN
         r_lsr[0] <= w_wrap;
         for (int i = 1; i < ROM_LATENCY; i++)
            r_lsr[i] <= r_lsr[i-1];
`endif
         if (w_push)
            r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
         if (w_pop)
            r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
         r_count <= w_count_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr]  <= bus.rom_q;
`ifdef PARAM_STREAM_LAST_EN
         r_lmem[r_wr_ptr] <= r_lsr[ROM_LATENCY-1];
`endif
      end
   end

   assign bus.busy           = r_busy;
   assign bus.done           = r_done;
   assign bus.rom_addr       = r_addr;
   assign bus.rom_ce         = 1'b1;
   assign bus.data_out       = r_mem[r_rd_ptr];
   assign bus.data_out_valid = (r_count != '0);
`ifdef PARAM_STREAM_LAST_EN
   assign bus.data_out_last  = (r_count != '0) && r_lmem[r_rd_ptr];
`endif
endmodule

// File: tb/tb_param_rom_stream_ctrl.sv
// Randomized bench for param_rom_stream_ctrl against a word-sequence model.
// Build with PARAM_STREAM_LAST_EN to also check the last flag.
module tb_param_rom_stream_ctrl;
   localparam int DW = 16;
   localparam int OD = 32;
   localparam int PW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   param_rom_stream_ctrl_if #(
      .DATA_WIDTH(DW), .OUT_DEPTH(OD), .PASS_WIDTH(PW)
   ) bus ();

   param_rom_stream_ctrl #(
      .DATA_WIDTH(DW), .OUT_DEPTH(OD), .ROM_LATENCY(2),
      .FIFO_DEPTH(3), .PASS_WIDTH(PW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Two-cycle ROM: q = address + 0x100
   logic [DW-1:0] rom_p1;
   always @(posedge clk) begin
      rom_p1    <= DW'(bus.rom_addr) + 16'h100;
      bus.rom_q <= rom_p1;
   end

   task automatic check(input string tag, input longint got,
                        input longint exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic rdy(input int pct);
      return $urandom_range(0, 99) < pct;
   endfunction

   task automatic run_job(input int passes, input int pct,
                          input bit timed, input int restart_cyc);
      logic [DW-1:0] exp_q[$];
      logic [DW-1:0] w;
      logic [DW-1:0] prev_data;
      bit   stall;
      int   hs, first_hs, last_hs, dones, done_cyc;
      int   busy_bad, busy_at_done, c, limit;
      for (int p = 0; p < passes; p++)
         for (int a = 0; a < OD; a++)
            exp_q.push_back(DW'(a) + 16'h100);
      hs = 0; first_hs = -1; last_hs = -1;
      dones = 0; done_cyc = -1; busy_bad = 0;
      busy_at_done = 1; stall = 0; prev_data = '0;
      limit = passes * OD * 12 + 50;
      @(posedge clk); #1;
      bus.start          = 1'b1;
      bus.pass_count     = PW'(passes);
      bus.data_out_ready = rdy(pct);
      for (c = 0; c < limit; c++) begin
         @(negedge clk);
         if (stall) begin
            check("hold_valid", longint'(bus.data_out_valid), 1);
            check("hold_data", longint'(bus.data_out), longint'(prev_data));
         end
         if (bus.data_out_valid && bus.data_out_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_word", hs + 1, passes * OD);
            end else begin
               w = exp_q.pop_front();
               check("data", longint'(bus.data_out), longint'(w));
`ifdef PARAM_STREAM_LAST_EN
               check("last", longint'(bus.data_out_last),
                     longint'(w == 16'h11F));
`endif
            end
            if (first_hs < 0) first_hs = c;
            last_hs = c;
            hs++;
         end
         stall     = bus.data_out_valid && !bus.data_out_ready;
         prev_data = bus.data_out;
         if (bus.done) begin
            dones++;
            done_cyc     = c;
            busy_at_done = int'(bus.busy);
         end
         if (timed && (bus.busy != (c >= 1 && c <= 3 + passes * OD)))
            busy_bad++;
         if (done_cyc >= 0 && c >= done_cyc + 2) break;
         @(posedge clk); #1;
         bus.start = (c + 1 == restart_cyc);
         if (c + 1 == restart_cyc) bus.pass_count = PW'(5);
         bus.data_out_ready = rdy(pct);
      end
      check("timeout", longint'(c < limit), 1);
      check("word_count", hs, passes * OD);
      check("done_pulses", dones, 1);
      check("busy_at_done", busy_at_done, 0);
      if (timed) begin
         check("first_cycle", first_hs, 4);
         check("last_cycle", last_hs, 3 + passes * OD);
         check("done_cycle", done_cyc, 4 + passes * OD);
         check("busy_window", busy_bad, 0);
      end
   endtask

   initial begin
      bus.start          = 1'b0;
      bus.pass_count     = '0;
      bus.data_out_ready = 1'b0;
      rst                = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", longint'(bus.busy), 0);
      check("rst_done", longint'(bus.done), 0);
      check("rst_valid", longint'(bus.data_out_valid), 0);
      check("rst_addr", longint'(bus.rom_addr), 0);
      check("rst_ce", longint'(bus.rom_ce), 1);
`ifdef PARAM_STREAM_LAST_EN
      check("rst_last", longint'(bus.data_out_last), 0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;

      run_job(1, 100, 1'b1, -1);
      run_job(1, 50, 1'b0, -1);
      run_job(3, 100, 1'b1, -1);

      @(posedge clk); #1;
      bus.start      = 1'b1;
      bus.pass_count = '0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("zero_pass_busy", longint'(bus.busy), 0);
         check("zero_pass_valid", longint'(bus.data_out_valid), 0);
      end

      run_job(1, 100, 1'b1, 10);
      run_job(2, 50, 1'b0, -1);
      run_job(3, 50, 1'b0, -1);

      @(posedge clk); #1;
      bus.start          = 1'b1;
      bus.pass_count     = PW'(1);
      bus.data_out_ready = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      @(negedge clk);
      check("pre_rst_valid", longint'(bus.data_out_valid), 1);
      check("pre_rst_busy", longint'(bus.busy), 1);
      check("pre_rst_addr", longint'(bus.rom_addr), 3);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_valid", longint'(bus.data_out_valid), 0);
      check("post_rst_busy", longint'(bus.busy), 0);
      check("post_rst_addr", longint'(bus.rom_addr), 0);
      for (int i = 0; i < 5; i++) begin
         check("post_rst_done", longint'(bus.done), 0);
         check("post_rst_idle", longint'(bus.data_out_valid), 0);
         @(negedge clk);
      end

      run_job(1, 100, 1'b1, -1);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end
endmodule
